// File: rtl/display_pkg.sv
// Shared types and default sizing for the garbled display frame sequencer.
package display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_EVAL,
    ST_CAPTURE,
    ST_STREAM
  } state_e;

  localparam int          DEF_WIDTH       = 120;
  localparam int          DEF_HEIGHT      = 52;
  localparam int          DEF_RNDSIZE     = 16;
  localparam int          DEF_NB_SEGMENTS = 16;
  localparam int          DEF_EVAL_CYCLES = 2;
  localparam logic [15:0] DEF_LFSR_TAPS   = 16'hB400;

endpackage

// File: rtl/lfsr_galois_step.sv
// One step of a right-shifting Galois LFSR; purely combinational.
module lfsr_galois_step #(
  parameter int                 RNDSIZE = 16,
  parameter logic [RNDSIZE-1:0] TAPS    = 16'hB400
) (
  input  logic [RNDSIZE-1:0] state_i,
  output logic [RNDSIZE-1:0] next_o
);

  assign next_o = {1'b0, state_i[RNDSIZE-1:1]} ^ (state_i[0] ? TAPS : '0);

endmodule

// File: rtl/display_frame_sequencer.sv
// Drives the garbled display core once per frame, snapshots its pixels and
// streams the snapshot out one row per valid/ready beat.
module display_frame_sequencer
  import display_pkg::*;
#(
  parameter int                 WIDTH       = DEF_WIDTH,
  parameter int                 HEIGHT      = DEF_HEIGHT,
  parameter int                 RNDSIZE     = DEF_RNDSIZE,
  parameter int                 NB_SEGMENTS = DEF_NB_SEGMENTS,
  parameter int                 EVAL_CYCLES = DEF_EVAL_CYCLES,
  parameter logic [RNDSIZE-1:0] LFSR_TAPS   = RNDSIZE'(DEF_LFSR_TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_load,
  input  logic                    cfg_z,
  input  logic [NB_SEGMENTS-1:0]  cfg_msg,
  input  logic [RNDSIZE-1:0]      cfg_seed,
  input  logic [15:0]             cfg_nframes,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    core_z,
  output logic [NB_SEGMENTS-1:0]  core_msg,
  output logic [RNDSIZE-1:0]      core_rnd,
  input  logic [WIDTH*HEIGHT-1:0] core_pix,
  output logic [WIDTH-1:0]        row_data,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic                    row_last,
  output logic [15:0]             frame_idx
);

  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CNT_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVAL_CYCLES - 1);

  state_e                  state_q, state_d;
  logic                    done_q, done_d;
  logic [RNDSIZE-1:0]      lfsr_q, lfsr_next, rnd_q;
  logic                    z_q;
  logic [NB_SEGMENTS-1:0]  msg_q;
  logic [15:0]             nframes_q, frame_idx_q;
  logic [ROW_W-1:0]        row_q;
  logic [CNT_W-1:0]        eval_cnt_q;
  logic [WIDTH*HEIGHT-1:0] fbuf_q;
  logic [WIDTH-1:0]        rows [HEIGHT];
  logic                    beat, last_frame;

  lfsr_galois_step #(
    .RNDSIZE (RNDSIZE),
    .TAPS    (LFSR_TAPS)
  ) u_lfsr_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_next)
  );

  for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_rows
    assign rows[gi] = fbuf_q[gi*WIDTH +: WIDTH];
  end

  assign beat       = (state_q == ST_STREAM) && row_ready;
  assign last_frame = (nframes_q != 16'd0) && ((frame_idx_q + 16'd1) == nframes_q);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      // A same-cycle cfg_load takes precedence, so start is dropped.
      ST_IDLE:    if (start && !cfg_load) state_d = ST_SEED;
      ST_SEED:    state_d = ST_EVAL;
      ST_EVAL:    if (eval_cnt_q == EVAL_LAST) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_STREAM;
      ST_STREAM: begin
        if (beat && (row_q == LAST_ROW)) begin
          if (last_frame) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SEED;
          end
        end
      end
      default:    state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      lfsr_q      <= RNDSIZE'(1);
      rnd_q       <= '0;
      z_q         <= 1'b0;
      msg_q       <= '0;
      nframes_q   <= '0;
      frame_idx_q <= '0;
      row_q       <= '0;
      eval_cnt_q  <= '0;
      fbuf_q      <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      case (state_q)
        ST_IDLE: begin
          if (cfg_load) begin
            z_q       <= cfg_z;
            msg_q     <= cfg_msg;
            nframes_q <= cfg_nframes;
            // An all-zero seed would lock the LFSR at zero forever.
            lfsr_q    <= (cfg_seed == '0) ? RNDSIZE'(1) : cfg_seed;
          end else if (start) begin
            frame_idx_q <= '0;
          end
        end
        ST_SEED: begin
          rnd_q      <= lfsr_q;
          eval_cnt_q <= '0;
        end
        ST_EVAL:    eval_cnt_q <= eval_cnt_q + CNT_W'(1);
        ST_CAPTURE: begin
          fbuf_q <= core_pix;
          lfsr_q <= lfsr_next;
          row_q  <= '0;
        end
        ST_STREAM: begin
          if (beat) begin
            if (row_q == LAST_ROW) begin
              row_q <= '0;
              if (!last_frame) frame_idx_q <= frame_idx_q + 16'd1;
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign core_z    = z_q;
  assign core_msg  = msg_q;
  assign core_rnd  = rnd_q;
  assign row_valid = (state_q == ST_STREAM);
  assign row_last  = row_valid && (row_q == LAST_ROW);
  assign row_data  = row_valid ? rows[row_q] : '0;
  assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Self-checking bench: table of runs plus hand sequences for abort, busy-ignore and reset.
module tb_display_frame_sequencer;

  localparam int WIDTH = 4, HEIGHT = 3, RNDSIZE = 8, NB_SEGMENTS = 16, EVAL_CYCLES = 2;

  logic                    clk, rst;
  logic                    cfg_load, cfg_z, start, abort;
  logic [NB_SEGMENTS-1:0]  cfg_msg;
  logic [RNDSIZE-1:0]      cfg_seed;
  logic [15:0]             cfg_nframes;
  logic                    busy, done, core_z, row_valid, row_ready, row_last;
  logic [NB_SEGMENTS-1:0]  core_msg;
  logic [RNDSIZE-1:0]      core_rnd;
  logic [WIDTH*HEIGHT-1:0] core_pix;
  logic [WIDTH-1:0]        row_data;
  logic [15:0]             frame_idx;

  display_frame_sequencer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .RNDSIZE(RNDSIZE), .NB_SEGMENTS(NB_SEGMENTS),
    .EVAL_CYCLES(EVAL_CYCLES), .LFSR_TAPS(8'hB8)
  ) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_z(cfg_z), .cfg_msg(cfg_msg),
    .cfg_seed(cfg_seed), .cfg_nframes(cfg_nframes), .start(start), .abort(abort),
    .busy(busy), .done(done), .core_z(core_z), .core_msg(core_msg), .core_rnd(core_rnd),
    .core_pix(core_pix), .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
    .row_last(row_last), .frame_idx(frame_idx)
  );

  // Core model: rows 0..2 carry rnd low nibble, high nibble, low nibble.
  assign core_pix = {core_rnd[3:0], core_rnd[7:4], core_rnd[3:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  data;
    logic        last;
    logic [15:0] idx;
    logic [7:0]  rnd;
  } beat_t;

  typedef struct {
    logic [7:0]  seed;
    logic [15:0] nfr;
    logic        z;
    logic [15:0] msg;
    int          ready_mode;
    logic [7:0]  exp_rnd0;
    int          exp_cycles;
  } vec_t;

  beat_t exp_q[$];
  int    checks = 0, failures = 0;
  int    done_cnt = 0, beats = 0;
  int    ready_mode = 0;
  logic  stall_q = 1'b0, held_last;
  logic [3:0] held_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  // Queue nfr full frames, then 'extra' leading rows of one more frame.
  task automatic push_frames(input logic [7:0] rnd0, input int nfr, input int extra,
                             output logic [7:0] r_out);
    logic [7:0] r;
    beat_t b;
    r = rnd0;
    for (int k = 0; k <= nfr; k++) begin
      for (int j = 0; j < ((k < nfr) ? 3 : extra); j++) begin
        b.data = (j == 1) ? r[7:4] : r[3:0];
        b.last = (j == 2);
        b.idx  = 16'(k);
        b.rnd  = r;
        exp_q.push_back(b);
      end
      if (k < nfr) r = lfsr_step(r);
    end
    r_out = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] seed, input logic [15:0] nfr,
                          input logic z, input logic [15:0] msg);
    cfg_seed = seed; cfg_nframes = nfr; cfg_z = z; cfg_msg = msg; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (done !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  always @(posedge clk) begin
    #1;
    row_ready = (ready_mode == 0) ? 1'b1 : ~row_ready;
  end

  // Output monitor: one line per accepted beat, scoreboard compare, hold checks.
  always @(negedge clk) begin
    beat_t e;
    if (done) done_cnt++;
    if (stall_q) begin
      check("hold_valid", {31'd0, row_valid}, 32'd1);
      check("hold_data", {28'd0, row_data}, {28'd0, held_data});
      check("hold_last", {31'd0, row_last}, {31'd0, held_last});
    end
    stall_q   = row_valid && !row_ready;
    held_data = row_data;
    held_last = row_last;
    if (row_valid && row_ready) begin
      beats++;
      $display("beat %0d: frame=%0d data=%h last=%b rnd=%h", beats, frame_idx, row_data, row_last, core_rnd);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: actual=data %h required=no beat", row_data);
      end else begin
        e = exp_q.pop_front();
        check("row_data", {28'd0, row_data}, {28'd0, e.data});
        check("row_last", {31'd0, row_last}, {31'd0, e.last});
        check("frame_idx", {16'd0, frame_idx}, {16'd0, e.idx});
        check("core_rnd", {24'd0, core_rnd}, {24'd0, e.rnd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[4];
  logic [7:0] r;
  int cyc, dc;

  initial begin
    vecs[0] = '{8'h01, 16'd3, 1'b1, 16'h1234, 0, 8'h01, 22};
    vecs[1] = '{8'h00, 16'd1, 1'b0, 16'h00F0, 0, 8'h01, 8};
    vecs[2] = '{8'h01, 16'd1, 1'b1, 16'hABCD, 1, 8'h01, 0};
    vecs[3] = '{8'h5C, 16'd2, 1'b0, 16'h8001, 0, 8'h5C, 15};

    rst = 1'b1; cfg_load = 0; cfg_z = 0; cfg_msg = '0; cfg_seed = '0; cfg_nframes = '0;
    start = 0; abort = 0; row_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, row_valid}, 32'd0);
    check("rst_rnd", {24'd0, core_rnd}, 32'd0);
    check("rst_frame_idx", {16'd0, frame_idx}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      ready_mode = vecs[i].ready_mode;
      load_cfg(vecs[i].seed, vecs[i].nfr, vecs[i].z, vecs[i].msg);
      check("cfg_z", {31'd0, core_z}, {31'd0, vecs[i].z});
      check("cfg_msg", {16'd0, core_msg}, {16'd0, vecs[i].msg});
      push_frames(vecs[i].exp_rnd0, int'(vecs[i].nfr), 0, r);
      dc = done_cnt;
      start = 1'b1; tick(); start = 1'b0; cyc = 1;
      check("start_busy", {31'd0, busy}, 32'd1);
      tick(); cyc++;
      check("first_rnd", {24'd0, core_rnd}, {24'd0, vecs[i].exp_rnd0});
      wait_done(cyc);
      check("done_busy", {31'd0, busy}, 32'd0);
      if (vecs[i].exp_cycles != 0) check("run_cycles", cyc, vecs[i].exp_cycles);
      repeat (3) tick();
      check("done_pulses", done_cnt, dc + 1);
      check("queue_drained", exp_q.size(), 32'd0);
    end

    // Load and start together: start is dropped; then config is frozen while busy.
    ready_mode = 0;
    cfg_seed = 8'h01; cfg_nframes = 16'd2; cfg_z = 1'b1; cfg_msg = 16'hA5A5;
    cfg_load = 1'b1; start = 1'b1; tick(); cfg_load = 1'b0; start = 1'b0;
    tick();
    check("load_beats_start", {31'd0, busy}, 32'd0);
    push_frames(8'h01, 2, 0, r);
    dc = done_cnt;
    start = 1'b1; tick(); start = 1'b0; cyc = 1;
    repeat (2) begin tick(); cyc++; end
    cfg_seed = 8'h77; cfg_nframes = 16'd9; cfg_z = 1'b0; cfg_msg = 16'h0000;
    cfg_load = 1'b1; start = 1'b1; tick(); cyc++; cfg_load = 1'b0; start = 1'b0;
    wait_done(cyc);
    check("busy_ign_cycles", cyc, 15);
    check("busy_ign_z", {31'd0, core_z}, 32'd1);
    check("busy_ign_msg", {16'd0, core_msg}, 32'h0000A5A5);
    repeat (2) tick();
    check("busy_ign_done", done_cnt, dc + 1);

    // Continuous run aborted on frame 5's second beat.
    load_cfg(8'h01, 16'd0, 1'b0, 16'h0F0F);
    push_frames(8'h01, 5, 2, r);
    dc = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    check("abort_frame_idx", {16'd0, frame_idx}, 32'd5);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_valid", {31'd0, row_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_queue", exp_q.size(), 32'd0);
    repeat (3) tick();
    check("abort_no_done", done_cnt, dc);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("restart_rnd", {24'd0, core_rnd}, {24'd0, lfsr_step(r)});
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_eval_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset while streaming.
    load_cfg(8'h5C, 16'd2, 1'b1, 16'h5A5A);
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("pre_rst_valid", {31'd0, row_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, row_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_last", {31'd0, row_last}, 32'd0);
    check("mid_rst_data", {28'd0, row_data}, 32'd0);
    check("mid_rst_rnd", {24'd0, core_rnd}, 32'd0);
    check("mid_rst_z", {31'd0, core_z}, 32'd0);
    check("mid_rst_msg", {16'd0, core_msg}, 32'd0);
    check("mid_rst_idx", {16'd0, frame_idx}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("post_rst_rnd", {24'd0, core_rnd}, 32'h01);
    abort = 1'b1; tick(); abort = 1'b0;
    check("post_rst_abort", {31'd0, busy}, 32'd0);
    check("final_queue", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
